// File: rtl/spi_conf_pkg.sv
// Shared constants and FSM encoding for the SPI configuration responder.
package spi_conf_pkg;

  localparam int CONF_SIZE_DEF = 21;
  localparam int ADDR_W_DEF    = 4;

  // Frame header is {R/W, addr}; R/W sits just above the address bits.
  function automatic int hdr_rw_pos(input int addr_w);
    return addr_w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop, with rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability stage, [1] synced value, [2] previous synced value
  logic [2:0] sr_q, sr_d;

  // shift the pad value through the chain
  always_comb begin
    sr_d = {sr_q[1:0], d_i};
  end

  // chain registers, reset to the idle level of the pad
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sr_q <= {3{RST_VAL}};
    else        sr_q <= sr_d;
  end

  assign q_o    = sr_q[1];
  assign rise_o = sr_q[1] & ~sr_q[2];
  assign fall_o = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_conf_responder.sv
// 3-wire SPI configuration responder with local register file.
module spi_conf_responder import spi_conf_pkg::*; #(
  parameter  int CONF_SIZE = CONF_SIZE_DEF,
  parameter  int ADDR_W    = ADDR_W_DEF,
  localparam int DATA_W    = CONF_SIZE - 1 - ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_csb_i,
  input  logic              spi_sdio_i,
  output logic              spi_sdio_o,
  output logic              spi_sdio_oe_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rd_done_o,
  output logic              frame_err_o,
  output logic              busy_o,
  input  logic [ADDR_W-1:0] reg_addr_i,
  output logic [DATA_W-1:0] reg_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(CONF_SIZE + 2);
  localparam int RW_POS = hdr_rw_pos(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONF_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CONF_SIZE + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csb_s, csb_rise, csb_fall;
  logic sdio_s, sdio_rise, sdio_fall;

  // sclk idles high; csb resets low so a frame in flight at reset release
  // never produces a falling edge and is ignored.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_clk_i),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_csb (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_csb_i),
    .q_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdio (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sdio_i),
    .q_o(sdio_s), .rise_o(sdio_rise), .fall_o(sdio_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_s, csb_s, sdio_rise, sdio_fall};

  state_e               state_q, state_d;
  logic [CONF_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d;
  logic                 wr_valid_q, wr_valid_d, rd_done_q, rd_done_d;
  logic                 frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [DATA_W-1:0]    reg_data_q, reg_data_d;
  logic                 reg_we;
  logic [DATA_W-1:0]    regs_q [DEPTH];

  // frame decode: next state, shifting, counting, pulses and pad drive
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_valid_d  = 1'b0;
    rd_done_d   = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    if (state_q == ST_IDLE) begin
      if (csb_fall) begin
        shift_d = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = ST_ADDR;
      end
    end else if (csb_rise) begin
      // csb rise wins over any sclk edge seen in the same cycle
      oe_d    = 1'b0;
      sdo_d   = 1'b0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
      if (cnt_q == CNT_FULL && state_q == ST_WDATA) begin
        reg_we     = 1'b1;
        wr_valid_d = 1'b1;
        wr_addr_d  = shift_q[CONF_SIZE-2 -: ADDR_W];
        wr_data_d  = shift_q[DATA_W-1:0];
      end else if (cnt_q == CNT_FULL && state_q == ST_RDATA) begin
        rd_done_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_ADDR: if (sclk_rise) begin
          shift_d = {shift_q[CONF_SIZE-2:0], sdio_s};
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_HDR) begin
            if (shift_d[RW_POS]) begin
              rdata_d = regs_q[shift_d[ADDR_W-1:0]];
              state_d = ST_RDATA;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_WDATA: if (sclk_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q < CNT_FULL) shift_d = {shift_q[CONF_SIZE-2:0], sdio_s};
          else                  state_d = ST_IGNORE;
        end
        ST_RDATA: begin
          if (sclk_rise) cnt_d = cnt_inc;
          if (sclk_fall) begin
            oe_d    = 1'b1;
            sdo_d   = rdata_q[DATA_W-1];
            rdata_d = {rdata_q[DATA_W-2:0], 1'b0};
          end
        end
        ST_IGNORE: if (sclk_rise) cnt_d = cnt_inc;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // local read port sees the pre-write value on a same-address collision
  always_comb begin
    reg_data_d = regs_q[reg_addr_i];
  end

  // control and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_valid_q  <= wr_valid_d;
      rd_done_q   <= rd_done_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      reg_data_q  <= reg_data_d;
    end
  end

  // register file, written only by a complete write frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  // drop the pad driver in the same cycle the csb rise is seen
  assign spi_sdio_oe_o = oe_q & ~csb_rise;
  assign spi_sdio_o    = sdo_q;
  assign busy_o        = busy_q;
  assign wr_valid_o    = wr_valid_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign rd_done_o     = rd_done_q;
  assign frame_err_o   = frame_err_q;
  assign reg_data_o    = reg_data_q;

endmodule

// File: tb/tb_spi_conf_responder.sv
// Self-checking bench: SPI master stimulus against a register-file model.
module tb_spi_conf_responder;

  localparam int H = 5;  // sclk half period in clk_i cycles

  logic        clk_i = 1'b0;
  logic        rst_i, spi_clk_i, spi_csb_i, spi_sdio_i;
  logic        spi_sdio_o, spi_sdio_oe_o, wr_valid_o, rd_done_o, frame_err_o, busy_o;
  logic [3:0]  wr_addr_o, reg_addr_i;
  logic [15:0] wr_data_o, reg_data_o;

  spi_conf_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .spi_clk_i(spi_clk_i), .spi_csb_i(spi_csb_i),
    .spi_sdio_i(spi_sdio_i), .spi_sdio_o(spi_sdio_o), .spi_sdio_oe_o(spi_sdio_oe_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_done_o(rd_done_o), .frame_err_o(frame_err_o), .busy_o(busy_o),
    .reg_addr_i(reg_addr_i), .reg_data_o(reg_data_o));

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  int cyc = 0, rise_cyc = 0, wr_cyc = 0;
  int n_wr = 0, n_rd = 0, n_err = 0;
  logic [15:0] rd_at_wr;
  logic [19:0] wr_log[$];
  logic [15:0] mregs [16];

  always @(posedge clk_i) cyc <= cyc + 1;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (wr_valid_o) begin
      n_wr++; wr_cyc = cyc; rd_at_wr = reg_data_o;
      wr_log.push_back({wr_addr_o, wr_data_o});
    end
    if (rd_done_o)   n_rd++;
    if (frame_err_o) n_err++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic so, output logic soe);
    spi_clk_i = 1'b0; spi_sdio_i = b;
    wait_clk(H);
    so = spi_sdio_o; soe = spi_sdio_oe_o;
    spi_clk_i = 1'b1;
    wait_clk(H);
  endtask

  // Full master transaction: nbits of vec MSB first, then csb high for gap cycles.
  task automatic run_frame(input int nbits, input logic [31:0] vec, input int gap,
                           output logic [15:0] rd, output int oe_bad, output logic busy_mid);
    logic so, soe, is_rd;
    rd = '0; oe_bad = 0;
    is_rd = vec[nbits-1];
    spi_csb_i = 1'b0;
    wait_clk(6);
    busy_mid = busy_o;
    for (int i = 1; i <= nbits; i++) begin
      send_bit(vec[nbits-i], so, soe);
      if (i >= 6 && i <= 21) rd = {rd[14:0], so};
      if (soe !== (is_rd && i >= 6)) oe_bad++;
    end
    spi_csb_i = 1'b1; rise_cyc = cyc;
    wait_clk(gap);
  endtask

  function automatic logic [31:0] mk(input logic rw, input logic [3:0] a, input logic [15:0] d);
    return {11'b0, rw, a, d};
  endfunction

  task automatic test_reset;
    rst_i = 1'b0; spi_clk_i = 1'b1; spi_csb_i = 1'b1; spi_sdio_i = 1'b0; reg_addr_i = '0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    wait_clk(4);
    checks++;
    if ({wr_valid_o, rd_done_o, frame_err_o, busy_o, spi_sdio_oe_o, spi_sdio_o, wr_addr_o, wr_data_o, reg_data_o} !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rst_i = 1'b1;
    wait_clk(8);
    checks++;
    if (n_err !== 0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle: err_pulses=%0d busy=%b, expected 0/0", n_err, busy_o);
    end
    for (int a = 0; a < 16; a += 5) begin
      reg_addr_i = 4'(a); wait_clk(2);
      checks++;
      if (reg_data_o !== 16'h0) begin
        failures++; $display("FAIL reset_regs[%0d]: got %h expected 0000", a, reg_data_o);
      end
    end
  endtask

  task automatic test_write;
    logic [15:0] rd; int oe_bad; logic bm; int w0, e0; logic [15:0] old;
    reg_addr_i = 4'h3; old = mregs[3];
    wait_clk(2);
    w0 = n_wr; e0 = n_err;
    run_frame(21, mk(1'b0, 4'h3, 16'hA5C3), 10, rd, oe_bad, bm);
    mregs[3] = 16'hA5C3;
    checks++;
    if (n_wr - w0 !== 1 || n_err !== e0) begin
      failures++; $display("FAIL write_pulse: wr=%0d err=%0d expected 1/0", n_wr - w0, n_err - e0);
    end
    checks++;
    if (wr_cyc - rise_cyc < 2 || wr_cyc - rise_cyc > 5) begin
      failures++; $display("FAIL write_latency: got %0d cycles expected 2..5", wr_cyc - rise_cyc);
    end
    checks++;
    if (wr_addr_o !== 4'h3 || wr_data_o !== 16'hA5C3) begin
      failures++; $display("FAIL write_addr_data: got %h/%h expected 3/a5c3", wr_addr_o, wr_data_o);
    end
    checks++;
    if (rd_at_wr !== old) begin
      failures++; $display("FAIL write_collision_old: got %h expected %h", rd_at_wr, old);
    end
    checks++;
    if (reg_data_o !== mregs[3]) begin
      failures++; $display("FAIL write_readport: got %h expected %h", reg_data_o, mregs[3]);
    end
    checks++;
    if (bm !== 1'b1 || oe_bad !== 0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL write_busy_oe: busy_mid=%b oe_bad=%0d busy_end=%b expected 1/0/0", bm, oe_bad, busy_o);
    end
  endtask

  task automatic test_read;
    logic [15:0] rd; int oe_bad; logic bm; int r0, w0;
    r0 = n_rd; w0 = n_wr;
    run_frame(21, mk(1'b1, 4'h3, 16'($urandom)), 3, rd, oe_bad, bm);
    checks++;
    if (spi_sdio_oe_o !== 1'b0) begin
      failures++; $display("FAIL read_oe_release: got %b expected 0", spi_sdio_oe_o);
    end
    wait_clk(6);
    checks++;
    if (rd !== mregs[3] || oe_bad !== 0) begin
      failures++; $display("FAIL read_data: got %h oe_bad=%0d expected %h/0", rd, oe_bad, mregs[3]);
    end
    checks++;
    if (n_rd - r0 !== 1 || n_wr !== w0) begin
      failures++; $display("FAIL read_pulse: rd=%0d wr=%0d expected 1/0", n_rd - r0, n_wr - w0);
    end
  endtask

  task automatic test_frame_err;
    logic [15:0] rd; int oe_bad; logic bm; int w0, e0;
    logic [31:0] v;
    w0 = n_wr;
    for (int k = 0; k < 2; k++) begin
      e0 = n_err;
      v = mk(1'b0, 4'h5, 16'hBEEF);
      if (k == 0) run_frame(20, v >> 1, 10, rd, oe_bad, bm);
      else        run_frame(23, (v << 2) | 32'h3, 10, rd, oe_bad, bm);
      checks++;
      if (n_err - e0 !== 1) begin
        failures++; $display("FAIL frame_err_%0d: got %0d pulses expected 1", k, n_err - e0);
      end
    end
    reg_addr_i = 4'h5; wait_clk(2);
    checks++;
    if (n_wr !== w0 || reg_data_o !== mregs[5]) begin
      failures++; $display("FAIL frame_err_nowrite: wr=%0d reg=%h expected 0/%h", n_wr - w0, reg_data_o, mregs[5]);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd; int oe_bad; logic bm, so, soe; int w0, r0, e0;
    logic [31:0] v; logic [15:0] d;
    w0 = n_wr; r0 = n_rd; e0 = n_err;
    v = mk(1'b0, 4'h7, 16'h5A5A);
    spi_csb_i = 1'b0; wait_clk(6);
    for (int i = 1; i <= 10; i++) send_bit(v[21-i], so, soe);
    rst_i = 1'b0; wait_clk(2);
    checks++;
    if (spi_sdio_oe_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL resetmid_abort: oe=%b busy=%b expected 0/0", spi_sdio_oe_o, busy_o);
    end
    rst_i = 1'b1; wait_clk(2);
    for (int i = 11; i <= 21; i++) send_bit(v[21-i], so, soe);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL resetmid_idle: busy=%b expected 0", busy_o);
    end
    spi_csb_i = 1'b1; wait_clk(10);
    reg_addr_i = 4'h7; wait_clk(2);
    checks++;
    if (n_wr !== w0 || n_rd !== r0 || n_err !== e0 || reg_data_o !== mregs[7]) begin
      failures++; $display("FAIL resetmid_nopulse: wr=%0d rd=%0d err=%0d reg=%h expected 0/0/0/%h",
                           n_wr - w0, n_rd - r0, n_err - e0, reg_data_o, mregs[7]);
    end
    d = 16'($urandom);
    run_frame(21, mk(1'b0, 4'h7, d), 10, rd, oe_bad, bm);
    mregs[7] = d;
    checks++;
    if (n_wr - w0 !== 1 || reg_data_o !== mregs[7]) begin
      failures++; $display("FAIL resetmid_recover: wr=%0d reg=%h expected 1/%h", n_wr - w0, reg_data_o, mregs[7]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd; int oe_bad; logic bm; int q0;
    q0 = wr_log.size();
    run_frame(21, mk(1'b0, 4'h0, 16'h1234), 4, rd, oe_bad, bm);
    run_frame(21, mk(1'b0, 4'hF, 16'hFFFF), 10, rd, oe_bad, bm);
    mregs[0] = 16'h1234; mregs[15] = 16'hFFFF;
    checks++;
    if (wr_log.size() - q0 !== 2) begin
      failures++; $display("FAIL b2b_count: got %0d writes expected 2", wr_log.size() - q0);
    end else begin
      checks++;
      if (wr_log[q0] !== 20'h01234 || wr_log[q0+1] !== 20'hFFFFF) begin
        failures++; $display("FAIL b2b_log: got %h,%h expected 01234,fffff", wr_log[q0], wr_log[q0+1]);
      end
    end
    run_frame(21, mk(1'b1, 4'hF, 16'h0), 10, rd, oe_bad, bm);
    checks++;
    if (rd !== mregs[15] || oe_bad !== 0) begin
      failures++; $display("FAIL b2b_readback: got %h oe_bad=%0d expected %h/0", rd, oe_bad, mregs[15]);
    end
  endtask

  task automatic test_random;
    logic [15:0] rd, d; int oe_bad; logic bm, rw; logic [3:0] a; int w0, r0;
    for (int k = 0; k < 10; k++) begin
      rw = 1'($urandom); a = 4'($urandom); d = 16'($urandom);
      w0 = n_wr; r0 = n_rd;
      run_frame(21, mk(rw, a, d), 10, rd, oe_bad, bm);
      checks++;
      if (rw) begin
        if (rd !== mregs[a] || oe_bad !== 0 || n_rd - r0 !== 1) begin
          failures++; $display("FAIL rand_read[%0d] a=%h: got %h oe_bad=%0d rd=%0d expected %h/0/1",
                               k, a, rd, oe_bad, n_rd - r0, mregs[a]);
        end
      end else begin
        mregs[a] = d;
        if (n_wr - w0 !== 1 || wr_addr_o !== a || wr_data_o !== d) begin
          failures++; $display("FAIL rand_write[%0d]: got %0d %h/%h expected 1 %h/%h",
                               k, n_wr - w0, wr_addr_o, wr_data_o, a, d);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
